mips_multicycle_ctrl: RTL and testbench

Multi-cycle control unit that sequences the MIPS datapath: PC, instruction register, register file, ALU and data memory. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives every datapath enable and mux select. It waits on a data-memory ready handshake, halts on unsupported opcodes, and counts retired instructions. It replaces the hand-driven `reg_write_enable`/`reg_write_register`/`dmem_write` stimulus in the top-level integration.

---
 rtl/mips_multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives the datapath enables and mux selects, traps illegal opcodes, counts retirements.
module mips_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        dmem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_write_enable,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        dmem_req,
  output logic        dmem_write,
  output logic        halt,
  output logic [31:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] count_r;
  logic        retire_s;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (op)
      OP_RTYPE: begin
        case (fn)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
      count_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      if (retire_s) begin
        count_r <= count_r + 32'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Next-state and datapath control decode; reset forces every output low
  always_comb begin
    state_next_s     = state_r;
    retire_s         = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 2'b00;
    alu_op           = 2'b00;
    alu_src_imm      = 1'b0;
    reg_write_enable = 1'b0;
    reg_dst          = 1'b0;
    mem_to_reg       = 1'b0;
    dmem_req         = 1'b0;
    dmem_write       = 1'b0;
    halt             = 1'b0;
    if (rst) begin
      state_next_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (run) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            state_next_s = S_DECODE;
          end else begin
            state_next_s = S_FETCH;
          end
        end
        S_DECODE: begin
          if (!is_legal(opcode, funct)) begin
            state_next_s = S_HALT;
          end else if (opcode == OP_J) begin
            pc_write     = 1'b1;
            pc_src       = 2'b10;
            retire_s     = 1'b1;
            state_next_s = S_FETCH;
          end else begin
            state_next_s = S_EXEC;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              alu_op       = 2'b10;
              state_next_s = S_WB;
            end
            OP_ADDI: begin
              alu_src_imm  = 1'b1;
              state_next_s = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_src_imm  = 1'b1;
              state_next_s = S_MEM;
            end
            OP_BEQ: begin
              alu_op       = 2'b01;
              pc_write     = alu_zero;
              pc_src       = 2'b01;
              retire_s     = 1'b1;
              state_next_s = S_FETCH;
            end
            default: state_next_s = S_HALT;
          endcase
        end
        S_MEM: begin
          dmem_req   = 1'b1;
          dmem_write = (opcode == OP_SW);
          if (!dmem_ready) begin
            state_next_s = S_MEM;
          end else if (opcode == OP_SW) begin
            retire_s     = 1'b1;
            state_next_s = S_FETCH;
          end else begin
            state_next_s = S_WB;
          end
        end
        S_WB: begin
          // ALU controls repeat the EXEC setting so alu_out stays stable into busW
          reg_write_enable = 1'b1;
          reg_dst          = (opcode == OP_RTYPE);
          mem_to_reg       = (opcode == OP_LW);
          alu_op           = (opcode == OP_RTYPE) ? 2'b10 : 2'b00;
          alu_src_imm      = (opcode != OP_RTYPE);
          retire_s         = 1'b1;
          state_next_s     = S_FETCH;
        end
        S_HALT: begin
          halt         = 1'b1;
          state_next_s = S_HALT;
        end
        default: begin
          halt         = 1'b1;
          state_next_s = S_HALT;
        end
      endcase
    end
  end

  assign instr_count = rst ? 32'd0 : count_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected controls are queued as
// stimulus is driven and popped/compared on the falling edge.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        alu_zero = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        ir_write, pc_write, alu_src_imm, reg_write_enable, reg_dst;
  logic        mem_to_reg, dmem_req, dmem_write, halt;
  logic [1:0]  pc_src, alu_op;
  logic [31:0] instr_count;

  typedef struct {
    string       tag;
    logic [12:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_count = 32'd0;
  localparam logic [12:0] ZERO = 13'd0;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .dmem_ready(dmem_ready), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .reg_write_enable(reg_write_enable), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .dmem_req(dmem_req), .dmem_write(dmem_write), .halt(halt), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Order: ir pcw pc_src alu_op imm rwe rdst m2r req wr halt
  function automatic logic [12:0] mk(input logic ir, input logic pcw, input logic [1:0] ps,
                                     input logic [1:0] ao, input logic imm, input logic rwe,
                                     input logic rdst, input logic m2r, input logic req,
                                     input logic wr, input logic hlt);
    return {ir, pcw, ps, ao, imm, rwe, rdst, m2r, req, wr, hlt};
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Compare the DUT against the oldest queued expectation away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, " ctl"}, {19'd0, ir_write, pc_write, pc_src, alu_op, alu_src_imm,
             reg_write_enable, reg_dst, mem_to_reg, dmem_req, dmem_write, halt}, {19'd0, e.ctl});
      check({e.tag, " cnt"}, instr_count, e.cnt);
    end
  end

  task automatic cyc(input string tag, input logic r, input logic rn, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic rdy, input logic [12:0] ectl);
    exp_t e;
    rst = r; run = rn; opcode = op; funct = fn; alu_zero = z; dmem_ready = rdy;
    e.tag = tag;
    e.ctl = ectl;
    e.cnt = r ? 32'd0 : exp_count;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic exec_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int nwait);
    logic is_r, is_lw, is_sw, legal;
    is_r  = (op == OP_R);
    is_lw = (op == OP_LW);
    is_sw = (op == OP_SW);
    legal = (is_r && (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})) ||
            (op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J});
    cyc({tag, " fetch"}, 1'b0, 1'b1, op, fn, rb(), rb(),
        mk(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    if (op == OP_J) begin
      cyc({tag, " decode"}, 1'b0, rb(), op, fn, rb(), rb(),
          mk(1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_count++;
      return;
    end
    cyc({tag, " decode"}, 1'b0, rb(), op, fn, rb(), rb(), ZERO);
    if (!legal) return;
    if (op == OP_BEQ) begin
      cyc({tag, " exec"}, 1'b0, rb(), op, fn, z, rb(),
          mk(1'b0, z, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_count++;
      return;
    end
    cyc({tag, " exec"}, 1'b0, rb(), op, fn, rb(), rb(),
        mk(1'b0, 1'b0, 2'b00, is_r ? 2'b10 : 2'b00, !is_r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    if (is_lw || is_sw) begin
      for (int i = 0; i < nwait; i++)
        cyc({tag, " memwait"}, 1'b0, rb(), op, fn, rb(), 1'b0,
            mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, is_sw, 1'b0));
      cyc({tag, " mem"}, 1'b0, rb(), op, fn, rb(), 1'b1,
          mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, is_sw, 1'b0));
      if (is_sw) begin
        exp_count++;
        return;
      end
    end
    cyc({tag, " wb"}, 1'b0, rb(), op, fn, rb(), rb(),
        mk(1'b0, 1'b0, 2'b00, is_r ? 2'b10 : 2'b00, !is_r, 1'b1, is_r, is_lw, 1'b0, 1'b0, 1'b0));
    exp_count++;
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc("rst0", 1'b1, 1'b1, OP_ADDI, 6'd0, 1'b1, 1'b1, ZERO);
    cyc("rst1", 1'b1, 1'b1, OP_ADDI, 6'd0, 1'b1, 1'b1, ZERO);
    exp_count = 32'd0;
    exec_instr("addi", OP_ADDI, 6'd0, 1'b0, 0);
    exec_instr("add", OP_R, 6'b100000, 1'b0, 0);
    exec_instr("sub", OP_R, 6'b100010, 1'b0, 0);
    exec_instr("and", OP_R, 6'b100100, 1'b0, 0);
    exec_instr("or", OP_R, 6'b100101, 1'b0, 0);
    exec_instr("slt", OP_R, 6'b101010, 1'b0, 0);
    exec_instr("lw3", OP_LW, 6'd0, 1'b0, 3);
    exec_instr("sw0", OP_SW, 6'd0, 1'b0, 0);
    exec_instr("lw0", OP_LW, 6'd0, 1'b0, 0);
    exec_instr("sw2", OP_SW, 6'd0, 1'b0, 2);
    exec_instr("beqT", OP_BEQ, 6'd0, 1'b1, 0);
    exec_instr("beqN", OP_BEQ, 6'd0, 1'b0, 0);
    exec_instr("j", OP_J, 6'd0, 1'b0, 0);
    for (int i = 0; i < 3; i++)
      cyc("idle", 1'b0, 1'b0, OP_ADDI, 6'd0, rb(), rb(), ZERO);
    // Reset arriving while a load is stalled in MEM
    cyc("rstmem fetch", 1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b0,
        mk(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("rstmem decode", 1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b0, ZERO);
    cyc("rstmem exec", 1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b0,
        mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("rstmem mem", 1'b0, 1'b1, OP_LW, 6'd0, 1'b0, 1'b0,
        mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("rstmem rst", 1'b1, 1'b1, OP_LW, 6'd0, 1'b0, 1'b0, ZERO);
    exp_count = 32'd0;
    exec_instr("addi2", OP_ADDI, 6'd0, 1'b0, 0);
    exec_instr("ill", 6'b111111, 6'd0, 1'b0, 0);
    for (int i = 0; i < 10; i++)
      cyc("halt", 1'b0, rb(), 6'b111111, 6'd0, rb(), rb(),
          mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc("halt rst", 1'b1, 1'b1, OP_ADDI, 6'd0, 1'b0, 1'b0, ZERO);
    exp_count = 32'd0;
    exec_instr("illfn", OP_R, 6'b000111, 1'b0, 0);
    for (int i = 0; i < 2; i++)
      cyc("halt2", 1'b0, 1'b1, OP_R, 6'b000111, rb(), rb(),
          mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc("halt2 rst", 1'b1, 1'b1, OP_ADDI, 6'd0, 1'b0, 1'b0, ZERO);
    exp_count = 32'd0;
    exec_instr("addi3", OP_ADDI, 6'd0, 1'b0, 0);
    exec_instr("j2", OP_J, 6'd0, 1'b0, 0);
    cyc("final", 1'b0, 1'b0, OP_ADDI, 6'd0, 1'b0, 1'b0, ZERO);
    @(negedge clk);
    #1;
    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
